// File: rtl/sid_regs_if.sv
// Host bus of the SID register block: chip select, write strobe, address,
// write data and registered read data.
interface sid_regs_if;
  logic       cs;
  logic       we;
  logic [4:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (output cs, output we, output addr, output data_in, input data_out);
  modport slave  (input cs, input we, input addr, input data_in, output data_out);
endinterface

// File: rtl/sid_regs.sv
// SID register file: voice/filter write registers, read-back of pots, osc3
// and env3, and a decaying bus latch that every other read returns.
module sid_regs #(
  parameter int DECAY_CYCLES = 8192,
  parameter int POT_PERIOD   = 512
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         ce_1m,
  sid_regs_if.slave    bus,
  input  logic [7:0]   osc3,
  input  logic [7:0]   env3,
  input  logic [7:0]   pot_x,
  input  logic [7:0]   pot_y,
  output logic [47:0]  freq,
  output logic [35:0]  pw,
  output logic [23:0]  control,
  output logic [23:0]  att_dec,
  output logic [23:0]  sus_rel,
  output logic [10:0]  fc,
  output logic [7:0]   res_filt,
  output logic [7:0]   mode_vol
);

  localparam int POT_W = (POT_PERIOD > 1) ? $clog2(POT_PERIOD) : 1;
  localparam logic [POT_W-1:0] POT_LAST   = POT_W'(POT_PERIOD - 1);
  localparam logic [15:0]      DECAY_INIT = 16'(DECAY_CYCLES);

  logic [7:0] freq_lo_q [0:2];
  logic [7:0] freq_hi_q [0:2];
  logic [7:0] pw_lo_q   [0:2];
  logic [3:0] pw_hi_q   [0:2];
  logic [7:0] control_q [0:2];
  logic [7:0] att_dec_q [0:2];
  logic [7:0] sus_rel_q [0:2];
  logic [2:0] fc_lo_q;
  logic [7:0] fc_hi_q;
  logic [7:0] res_filt_q;
  logic [7:0] mode_vol_q;

  logic [7:0]       pot_x_lat_q, pot_y_lat_q;
  logic [7:0]       bus_latch_q, bus_latch_d;
  logic [7:0]       data_out_q;
  logic [15:0]      decay_q, decay_d;
  logic [POT_W-1:0] pot_cnt_q, pot_cnt_d;
  logic             pot_wrap;

  logic       wr_en, rd_en;
  logic       voice_hit;
  logic [1:0] wr_voice;
  logic [2:0] wr_off;
  logic [7:0] rd_val;
  logic       rd_live;

  assign wr_en = bus.cs & bus.we;
  assign rd_en = bus.cs & ~bus.we;

  // Split a voice address (0x00-0x14) into voice number and register offset.
  always_comb begin
    voice_hit = 1'b0;
    wr_voice  = 2'd0;
    wr_off    = 3'd0;
    if (bus.addr < 5'd7) begin
      voice_hit = 1'b1;
      wr_voice  = 2'd0;
      wr_off    = bus.addr[2:0];
    end else if (bus.addr < 5'd14) begin
      voice_hit = 1'b1;
      wr_voice  = 2'd1;
      wr_off    = 3'(bus.addr - 5'd7);
    end else if (bus.addr < 5'd21) begin
      voice_hit = 1'b1;
      wr_voice  = 2'd2;
      wr_off    = 3'(bus.addr - 5'd14);
    end
  end

  // Read mux: live sources at 0x19-0x1C, everything else sees the bus latch.
  always_comb begin
    rd_val  = bus_latch_q;
    rd_live = 1'b1;
    case (bus.addr)
      5'h19:   rd_val = pot_x_lat_q;
      5'h1A:   rd_val = pot_y_lat_q;
      5'h1B:   rd_val = osc3;
      5'h1C:   rd_val = env3;
      default: rd_live = 1'b0;
    endcase
  end

  // Bus latch, decay timer and pot timer next state; any access beats a decay tick.
  always_comb begin
    bus_latch_d = bus_latch_q;
    decay_d     = decay_q;
    pot_cnt_d   = pot_cnt_q;
    pot_wrap    = 1'b0;
    if (wr_en) begin
      bus_latch_d = bus.data_in;
    end else if (rd_en) begin
      if (rd_live) bus_latch_d = rd_val;
    end else if (ce_1m && decay_q == 16'd1) begin
      bus_latch_d = 8'h00;
    end
    if (bus.cs) begin
      decay_d = DECAY_INIT;
    end else if (ce_1m && decay_q != 16'd0) begin
      decay_d = decay_q - 16'd1;
    end
    if (ce_1m) begin
      if (pot_cnt_q == POT_LAST) begin
        pot_cnt_d = '0;
        pot_wrap  = 1'b1;
      end else begin
        pot_cnt_d = pot_cnt_q + 1'b1;
      end
    end
  end

  // Write registers; writes land on any clock regardless of ce_1m.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        freq_lo_q[i] <= '0;
        freq_hi_q[i] <= '0;
        pw_lo_q[i]   <= '0;
        pw_hi_q[i]   <= '0;
        control_q[i] <= '0;
        att_dec_q[i] <= '0;
        sus_rel_q[i] <= '0;
      end
      fc_lo_q    <= '0;
      fc_hi_q    <= '0;
      res_filt_q <= '0;
      mode_vol_q <= '0;
    end else if (wr_en) begin
      if (voice_hit) begin
        case (wr_off)
          3'd0:    freq_lo_q[wr_voice] <= bus.data_in;
          3'd1:    freq_hi_q[wr_voice] <= bus.data_in;
          3'd2:    pw_lo_q[wr_voice]   <= bus.data_in;
          3'd3:    pw_hi_q[wr_voice]   <= bus.data_in[3:0];
          3'd4:    control_q[wr_voice] <= bus.data_in;
          3'd5:    att_dec_q[wr_voice] <= bus.data_in;
          default: sus_rel_q[wr_voice] <= bus.data_in;
        endcase
      end else begin
        case (bus.addr)
          5'h15:   fc_lo_q    <= bus.data_in[2:0];
          5'h16:   fc_hi_q    <= bus.data_in;
          5'h17:   res_filt_q <= bus.data_in;
          5'h18:   mode_vol_q <= bus.data_in;
          default: ;
        endcase
      end
    end
  end

  // Read data, bus latch, timers and pot latches.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data_out_q  <= '0;
      bus_latch_q <= '0;
      decay_q     <= '0;
      pot_cnt_q   <= '0;
      pot_x_lat_q <= '0;
      pot_y_lat_q <= '0;
    end else begin
      if (rd_en) data_out_q <= rd_val;
      bus_latch_q <= bus_latch_d;
      decay_q     <= decay_d;
      pot_cnt_q   <= pot_cnt_d;
      if (pot_wrap) begin
        pot_x_lat_q <= pot_x;
        pot_y_lat_q <= pot_y;
      end
    end
  end

  assign bus.data_out = data_out_q;

  for (genvar n = 0; n < 3; n++) begin : g_voice
    assign freq[16*n +: 16]   = {freq_hi_q[n], freq_lo_q[n]};
    assign pw[12*n +: 12]     = {pw_hi_q[n], pw_lo_q[n]};
    assign control[8*n +: 8]  = control_q[n];
    assign att_dec[8*n +: 8]  = att_dec_q[n];
    assign sus_rel[8*n +: 8]  = sus_rel_q[n];
  end

  assign fc       = {fc_hi_q, fc_lo_q};
  assign res_filt = res_filt_q;
  assign mode_vol = mode_vol_q;

endmodule

// File: tb/tb_sid_regs.sv
// Directed bench for sid_regs with short decay/pot periods.
module tb_sid_regs;
  localparam int DECAY = 16;
  localparam int POTP  = 8;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ce_1m;
  logic [7:0]  osc3, env3, pot_x, pot_y;
  logic [47:0] freq;
  logic [35:0] pw;
  logic [23:0] control, att_dec, sus_rel;
  logic [10:0] fc;
  logic [7:0]  res_filt, mode_vol;
  logic [7:0]  rv;

  int n_assert = 0;
  int n_fail   = 0;

  sid_regs_if bus ();

  sid_regs #(.DECAY_CYCLES(DECAY), .POT_PERIOD(POTP)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .ce_1m    (ce_1m),
    .bus      (bus),
    .osc3     (osc3),
    .env3     (env3),
    .pot_x    (pot_x),
    .pot_y    (pot_y),
    .freq     (freq),
    .pw       (pw),
    .control  (control),
    .att_dec  (att_dec),
    .sus_rel  (sus_rel),
    .fc       (fc),
    .res_filt (res_filt),
    .mode_vol (mode_vol)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.data_in = d;
    step();
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] v);
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a;
    step();
    bus.cs = 1'b0;
    v = bus.data_out;
  endtask

  // Read issued on the same edge as a ce_1m pulse.
  task automatic rd_ce(input logic [4:0] a, output logic [7:0] v);
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a; ce_1m = 1'b1;
    step();
    bus.cs = 1'b0; ce_1m = 1'b0;
    v = bus.data_out;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      ce_1m = 1'b1;
      step();
      ce_1m = 1'b0;
      step();
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; ce_1m = 1'b0;
    bus.cs = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.data_in = '0;
    osc3 = 8'hC3; env3 = 8'h3C; pot_x = 8'h80; pot_y = 8'h81;
    do_reset();

    chk("rst_freq", freq, 48'h0);
    chk("rst_mode_vol", {40'h0, mode_vol}, 48'h0);
    chk("rst_data_out", {40'h0, bus.data_out}, 48'h0);

    wr(5'h00, 8'h34); wr(5'h01, 8'h12); wr(5'h0E, 8'hCD); wr(5'h0F, 8'hAB);
    chk("freq_v0", {32'h0, freq[15:0]}, 48'h1234);
    chk("freq_v2", {32'h0, freq[47:32]}, 48'hABCD);
    chk("freq_v1", {32'h0, freq[31:16]}, 48'h0);

    wr(5'h15, 8'hFF); wr(5'h16, 8'h80); wr(5'h03, 8'hF7);
    chk("pw_hi_v0", {44'h0, pw[11:8]}, 48'h7);
    chk("fc", {37'h0, fc}, 48'h407);
    rd(5'h03, rv);
    chk("rd_03_latch", {40'h0, rv}, 48'hF7);

    wr(5'h0B, 8'h21); wr(5'h0C, 8'h42); wr(5'h14, 8'h99);
    wr(5'h10, 8'h55); wr(5'h11, 8'hFE); wr(5'h17, 8'hF1);
    chk("control_v1", {40'h0, control[15:8]}, 48'h21);
    chk("att_dec_v1", {40'h0, att_dec[15:8]}, 48'h42);
    chk("sus_rel_v2", {40'h0, sus_rel[23:16]}, 48'h99);
    chk("pw_v2", {36'h0, pw[35:24]}, 48'hE55);
    chk("res_filt", {40'h0, res_filt}, 48'hF1);

    wr(5'h19, 8'h77);
    chk("ign_wr_freq", freq, 48'hABCD_0000_1234);
    rd(5'h1D, rv);
    chk("ign_wr_latch", {40'h0, rv}, 48'h77);
    step(); step();
    chk("hold_data_out", {40'h0, bus.data_out}, 48'h77);

    wr(5'h04, 8'h5A);
    chk("control_v0", {40'h0, control[7:0]}, 48'h5A);
    ticks(DECAY - 1);
    rd(5'h1F, rv);
    chk("decay_minus1", {40'h0, rv}, 48'h5A);
    wr(5'h04, 8'h5A);
    ticks(DECAY);
    rd(5'h1F, rv);
    chk("decay_full", {40'h0, rv}, 48'h00);

    wr(5'h04, 8'h66);
    ticks(DECAY - 1);
    rd_ce(5'h1F, rv);
    chk("prio_rd", {40'h0, rv}, 48'h66);
    ticks(DECAY - 1);
    rd(5'h1F, rv);
    chk("prio_reload", {40'h0, rv}, 48'h66);

    do_reset();
    ticks(POTP - 1);
    rd(5'h19, rv);
    chk("pot_before", {40'h0, rv}, 48'h00);
    ticks(1);
    rd(5'h19, rv);
    chk("pot_x_after", {40'h0, rv}, 48'h80);
    rd(5'h1A, rv);
    chk("pot_y_after", {40'h0, rv}, 48'h81);
    pot_x = 8'h11;
    ticks(POTP - 1);
    rd_ce(5'h19, rv);
    chk("pot_same_edge", {40'h0, rv}, 48'h80);
    rd(5'h19, rv);
    chk("pot_new", {40'h0, rv}, 48'h11);
    rd(5'h1E, rv);
    chk("pot_rd_latch", {40'h0, rv}, 48'h11);

    rd(5'h1B, rv);
    chk("osc3", {40'h0, rv}, 48'hC3);
    rd(5'h1C, rv);
    chk("env3", {40'h0, rv}, 48'h3C);
    rd(5'h10, rv);
    chk("latch_env3", {40'h0, rv}, 48'h3C);

    wr(5'h18, 8'h0A);
    chk("mode_vol", {40'h0, mode_vol}, 48'h0A);
    rd(5'h1B, rv);
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr = 5'h18; bus.data_in = 8'h0F;
    reset_n = 1'b0;
    step();
    bus.cs = 1'b0; bus.we = 1'b0;
    reset_n = 1'b1;
    chk("rst_wr_mode_vol", {40'h0, mode_vol}, 48'h00);
    chk("rst_wr_data_out", {40'h0, bus.data_out}, 48'h00);
    chk("rst_wr_freq", freq, 48'h0);
    rd(5'h1D, rv);
    chk("rst_latch", {40'h0, rv}, 48'h00);
    rd(5'h19, rv);
    chk("rst_pot_lat", {40'h0, rv}, 48'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
